cmd_queue: RTL
==============

CMD_QUEUE -- requirements
Module: cmd_queue

Interface
REQ-001 Parameter DEPTH, default 4, is the command FIFO depth (power of two, minimum 2).
REQ-002 Parameter TIMEOUT, default 255, is the maximum number of WAIT_ACK cycles before a command is abandoned.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  upstream command valid.
REQ-006 in_ready  out  1  FIFO can accept a command.
REQ-007 in_data  in  8  command data byte.
REQ-008 in_row  in  1  target row.
REQ-009 in_col  in  2  target column.
REQ-010 in_action  in  3  command action code; 0 is NOP.
REQ-011 t_busy  in  1  transmitter busy.
REQ-012 r_busy  in  1  receiver busy.
REQ-013 d  out  8  data to the transmitter; bit i drives transmitter input di.
REQ-014 row  out  1  row to the transmitter/receiver pair.
REQ-015 col  out  2  column to the transmitter/receiver pair.
REQ-016 action  out  3  action strobe to the transmitter/receiver pair.
REQ-017 q_count  out  log2(DEPTH)+1  FIFO occupancy.
REQ-018 done  out  1  one-cycle pulse when a command completes.
REQ-019 timeout_err  out  1  one-cycle pulse when a command is abandoned.

Function
REQ-020 in_ready SHALL be (q_count < DEPTH), decoded from the registered count only, so a full FIFO refuses a push even in a cycle where it pops.
REQ-021 Push SHALL occur on in_valid && in_ready; when in_action == 0 the command SHALL be accepted and discarded, not enqueued.
REQ-022 Simultaneous push and pop SHALL leave q_count unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-023 The FSM SHALL have the states IDLE, ISSUE, WAIT_ACK and WAIT_DONE.
REQ-024 IDLE: if q_count > 0, t_busy == 0 and r_busy == 0, the FSM SHALL pop the head, register it into d/row/col, and move to ISSUE.
REQ-025 ISSUE: action SHALL equal the popped action for exactly one cycle, and the FSM SHALL then move to WAIT_ACK with the timer cleared.
REQ-026 action SHALL be 0 in every state other than ISSUE.
REQ-027 d/row/col SHALL hold from the pop until the next pop.
REQ-028 WAIT_ACK: t_busy == 1 SHALL move the FSM to WAIT_DONE; otherwise the timer SHALL increment.
REQ-029 WAIT_ACK: when the timer reaches TIMEOUT, timeout_err SHALL pulse for one cycle and the FSM SHALL return to IDLE.
REQ-030 WAIT_DONE: when t_busy == 0 and r_busy == 0, done SHALL pulse for one cycle and the FSM SHALL return to IDLE; there is no timeout in this state.
REQ-031 Latency: a push at edge N into an empty FIFO, with both busy lines low, SHALL produce action != 0 in the cycle after edge N+1.
REQ-032 The earliest next issue SHALL be the cycle after done plus one edge, i.e. at most one command is in flight.
REQ-033 done, timeout_err and action SHALL be registered outputs.

Reset
REQ-034 While rst is low: FSM = IDLE; pointers, q_count and timer = 0; d = 0; row = 0; col = 0; action = 0; done = 0; timeout_err = 0; in_ready = 1.
REQ-035 Reset asserted mid-command SHALL drop the in-flight command and all queued commands, with no done or timeout_err pulse.

Verification
REQ-036 Single command (data 0xA5, row 1, col 2, action 3), both busy lines idle, t_busy high 1 cycle after ISSUE for 10 cycles -> action = 3 for exactly one cycle two edges after push; d = 0xA5, row = 1, col = 2 held; done pulses once when t_busy falls.
REQ-037 Push 5 commands back-to-back with DEPTH = 4 and t_busy held high -> in_ready low after 4 pushes, 5th stalls, q_count = 4, no action issued.
REQ-038 NOP push (action 0) -> accepted, q_count stays 0, no issue.
REQ-039 t_busy never rises after ISSUE -> timeout_err pulses TIMEOUT cycles after entry to WAIT_ACK, FIFO head advances to the next command.
REQ-040 r_busy held high after t_busy falls -> no done until r_busy falls; the next queued command is not issued earlier.
REQ-041 rst pulsed low in WAIT_DONE with 3 queued -> all outputs at reset values asynchronously, q_count = 0, no pulses.

Source files
------------

// File: rtl/cmd_queue.sv
// Command FIFO feeding a transmitter/receiver pair, with one command in flight at a time.
// Each command is issued as a one-cycle action strobe, then the block waits for busy handshakes or a timeout.
module cmd_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    input  logic                     in_row,
    input  logic [1:0]               in_col,
    input  logic [2:0]               in_action,
    input  logic                     t_busy,
    input  logic                     r_busy,
    output logic [7:0]               d,
    output logic                     row,
    output logic [1:0]               col,
    output logic [2:0]               action,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     done,
    output logic                     timeout_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef struct packed {
        logic [7:0] data;
        logic       row;
        logic [1:0] col;
        logic [2:0] action;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    cmd_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic            r_in_ready;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_nxt;
    logic [7:0]      r_d;
    logic            r_row;
    logic [1:0]      r_col;
    logic [2:0]      r_action;
    logic            r_done;
    logic            r_tmo;
    logic            w_push;
    logic            w_pop;
    logic            w_done_nxt;
    logic            w_tmo_nxt;
    cmd_t            w_in_cmd;
    cmd_t            w_head;

    // NOP commands are acknowledged upstream but never stored.
    assign w_push   = in_valid && r_in_ready && (in_action != 3'd0);
    assign w_in_cmd = '{data: in_data, row: in_row, col: in_col, action: in_action};
    assign w_head   = r_mem[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Next-state and pulse decode for the issue/handshake sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_timer_nxt = r_timer;
        w_done_nxt  = 1'b0;
        w_tmo_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_count != CW'(0)) && !t_busy && !r_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_timer_nxt = TW'(0);
                w_state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (t_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_timer_nxt = TW'(TIMEOUT);
                    w_tmo_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!t_busy && !r_busy) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Queue bookkeeping; in_ready is precomputed so a full queue refuses pushes even while popping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt < CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_in_cmd;
    end

    // Command fields hold from one pop to the next; action is a single-cycle strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer  <= '0;
            r_d      <= '0;
            r_row    <= 1'b0;
            r_col    <= '0;
            r_action <= '0;
            r_done   <= 1'b0;
            r_tmo    <= 1'b0;
        end else begin
            r_timer  <= w_timer_nxt;
            r_action <= w_pop ? w_head.action : 3'd0;
            r_done   <= w_done_nxt;
            r_tmo    <= w_tmo_nxt;
            if (w_pop) begin
                r_d   <= w_head.data;
                r_row <= w_head.row;
                r_col <= w_head.col;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign q_count     = r_count;
    assign d           = r_d;
    assign row         = r_row;
    assign col         = r_col;
    assign action      = r_action;
    assign done        = r_done;
    assign timeout_err = r_tmo;

endmodule
